sincos_atan2: RTL
=================

# sincos_atan2

Iterative CORDIC vectoring-mode unit: the inverse of the sincos rotation block. It accepts a (cos, sin) pair and returns the angle atan2(sin, cos) and the vector magnitude. It sits beside the sincos unit in the t_block path and recovers joint angles from rotation-matrix terms for Jacobian checks. Its fixed-point formats match the sincos block.

## Interface
- ITER, 18: number of CORDIC micro-rotations; legal range 12–20.
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  start strobe; sampled only while busy=0.
- cos  input  21  signed x operand, Q2.19 (1.0 = 524288).
- sin  input  21  signed y operand, Q2.19.
- angle  output  21  signed result in radians, Q3.18 (π = 823550).
- mag  output  21  unsigned magnitude in Q2.19, including CORDIC gain K≈1.64676; saturates at 1048575.
- busy  output  1  high while iterating.
- valid  output  1  one-cycle pulse; angle and mag are valid in that cycle.

## Operation
- States:
  - IDLE: waiting for en.
  - ROT: iterating, counter i = 0..ITER-1.
  - DONE: presenting the result for one cycle.
- Start: en=1 at an edge in IDLE or DONE captures cos and sin, sign-extends both to 23-bit internal x and y, and applies pre-rotation:
  - x ≥ 0: x, y unchanged; z = 0.
  - x < 0 and y ≥ 0: (x, y) ← (y, −x); z = +411775 (π/2).
  - x < 0 and y < 0: (x, y) ← (−y, x); z = −411775.
  - The edge then enters ROT with i = 0.
- ROT step, one per edge, using arithmetic shifts:
  - y ≥ 0: x ← x + (y>>>i); y ← y − (x>>>i); z ← z + atan_tab[i].
  - y < 0: x ← x − (y>>>i); y ← y + (x>>>i); z ← z − atan_tab[i].
  - x and y in the right-hand sides are the pre-step values.
- atan_tab[i] = round(atan(2^−i)·2^18), stored as a 21-bit constant ROM. Entries i0..i3 are 205887, 121543, 64220, 32599.
- z is 21 bits wide. No overflow is possible because |z| ≤ π.
- After step i = ITER−1, the registers load as follows and the state goes to DONE:
  - angle ← z.
  - mag ← x, saturated to 1048575 if x ≥ 2^20.
  - valid ← 1.
- Zero vector: if captured cos = 0 and sin = 0, the block still runs ITER cycles but forces angle = 0 and mag = 0.
- Angle range: result lies in [−π, +π]. Input (−a, 0) with a > 0 yields +π.
- en while busy=1 is ignored; captured operands are not disturbed.
- DONE → IDLE at the next edge unless en=1, in which case a new operation starts (back-to-back).
- angle and mag hold their value until the next DONE load.

## Timing
- Reset (rst=0, asynchronous): state = IDLE, i = 0, and angle, mag, busy, valid all = 0. Internal x, y, z are cleared.
- Reset asserted mid-ROT aborts the operation: no valid pulse, all outputs = 0. After release the block is in IDLE.
- If edge k samples en=1:
  - busy = 1 after edge k.
  - valid = 1 and angle/mag updated after edge k+ITER.
  - busy = 0 after edge k+ITER.
  - valid = 0 after edge k+ITER+1.
- Latency is ITER cycles. Throughput is one result per ITER+1 cycles, using back-to-back en in DONE.
- Accuracy for nonzero input with |cos|, |sin| ≤ 524288:
  - |angle error| ≤ 8 LSB.
  - |mag − K·√(x²+y²)| ≤ 16 LSB before saturation.

## Test plan
- Basic angles (ITER=18):
  - cos=262144, sin=0, en pulse → valid exactly 18 edges later; angle = 0 ±8; mag = 431684 ±16.
  - cos=0, sin=262144 → angle = 411775 ±8.
- Left half-plane:
  - cos=−262144, sin=0 → angle = +823550 ±8 (not −π).
  - cos=−185364, sin=−185364 → angle = −617662 ±8.
- Zero vector and saturation:
  - cos=0, sin=0 → angle = 0, mag = 0, valid after 18 edges.
  - cos=524287, sin=524287 → mag = 1048575 (saturated); angle = 205887 ±8.
- Handshake:
  - en held high for 40 cycles with changing operands → results for operands captured at cycles 0, 19 and 38 only.
  - valid pulses are exactly one cycle wide; busy never high during a valid cycle.
- Reset mid-operation: assert rst=0 at iteration 7 → outputs 0 immediately (asynchronously). No valid pulse follows. A new en after release produces a correct result.
- Random sweep: 10k random angles with unit-ish magnitude → every angle within ±8 LSB of the atan2 reference model.

Source files
------------

// File: rtl/sincos_atan2.sv
// sincos_atan2: iterative CORDIC vectoring unit.
// Returns atan2(sin, cos) in Q3.18 and the K-scaled magnitude in Q2.19.
module sincos_atan2 #(
  parameter int ITER = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [20:0] cos,
  input  logic signed [20:0] sin,
  output logic signed [20:0] angle,
  output logic        [20:0] mag,
  output logic               busy,
  output logic               valid
);

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } state_t;

  localparam logic signed [20:0] HALF_PI = 21'sd411775;

  state_t             state, state_nx;
  logic        [4:0]  i;
  logic signed [22:0] x, y;
  logic signed [22:0] xc, yc, x0, y0;
  logic signed [22:0] xs, ys, xn, yn;
  logic signed [20:0] z, z0, zn, at;
  logic        [20:0] sat;
  logic               zero, start, last;

  function automatic logic signed [20:0] atan_tab(input logic [4:0] k);
    case (k)
      5'd0:    atan_tab = 21'sd205887;
      5'd1:    atan_tab = 21'sd121543;
      5'd2:    atan_tab = 21'sd64220;
      5'd3:    atan_tab = 21'sd32599;
      5'd4:    atan_tab = 21'sd16363;
      5'd5:    atan_tab = 21'sd8189;
      5'd6:    atan_tab = 21'sd4096;
      5'd7:    atan_tab = 21'sd2048;
      5'd8:    atan_tab = 21'sd1024;
      5'd9:    atan_tab = 21'sd512;
      5'd10:   atan_tab = 21'sd256;
      5'd11:   atan_tab = 21'sd128;
      5'd12:   atan_tab = 21'sd64;
      5'd13:   atan_tab = 21'sd32;
      5'd14:   atan_tab = 21'sd16;
      5'd15:   atan_tab = 21'sd8;
      5'd16:   atan_tab = 21'sd4;
      5'd17:   atan_tab = 21'sd2;
      5'd18:   atan_tab = 21'sd1;
      default: atan_tab = 21'sd0;
    endcase
  endfunction

  assign start = en && (state != ROT);
  assign last  = (state == ROT) && (i == 5'(ITER - 1));
  assign busy  = (state == ROT);
  assign valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = ROT;
      ROT:     if (last) state_nx = DONE;
      DONE:    state_nx = en ? ROT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Fold the left half-plane onto the right so the iterations converge.
  always_comb begin
    xc = {{2{cos[20]}}, cos};
    yc = {{2{sin[20]}}, sin};
    x0 = xc;
    y0 = yc;
    z0 = '0;
    if (xc[22]) begin
      if (!yc[22]) begin
        x0 = yc;
        y0 = -xc;
        z0 = HALF_PI;
      end else begin
        x0 = -yc;
        y0 = xc;
        z0 = -HALF_PI;
      end
    end
  end

  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    at = atan_tab(i);
    if (!y[22]) begin
      xn = x + ys;
      yn = y - xs;
      zn = z + at;
    end else begin
      xn = x - ys;
      yn = y + xs;
      zn = z - at;
    end
  end

  always_comb begin
    if (xn[22])            sat = '0;
    else if (|xn[21:20])   sat = 21'h0FFFFF;
    else                   sat = {1'b0, xn[19:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      i     <= '0;
      zero  <= 1'b0;
      angle <= '0;
      mag   <= '0;
    end else if (start) begin
      x    <= x0;
      y    <= y0;
      z    <= z0;
      i    <= '0;
      zero <= (cos == '0) && (sin == '0);
    end else if (state == ROT) begin
      x <= xn;
      y <= yn;
      z <= zn;
      i <= i + 5'd1;
      if (last) begin
        angle <= zero ? '0 : zn;
        mag   <= zero ? '0 : sat;
      end
    end
  end

endmodule
